alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter: size, 4, data width in bits of the result path; shall be legal for any value >= 1.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: flush  input  1  synchronous clear of all buffered entries.
REQ-005 Port: result  input  size  ALU operation result, captured when in_valid and in_ready are both 1.
REQ-006 Port: in_valid  input  1  result is valid this cycle.
REQ-007 Port: in_ready  output  1  buffer can accept a result this cycle.
REQ-008 Port: out_data  output  size  head-entry data.
REQ-009 Port: out_valid  output  1  out_data is valid.
REQ-010 Port: out_ready  input  1  consumer accepts the head entry this cycle.
REQ-011 Port: out_zero  output  1  head-entry zero flag.
REQ-012 Port: out_neg  output  1  head-entry negative flag, the MSB of the result.
REQ-013 Port: count  output  2  number of buffered entries, 0 to 2.

Function
REQ-014 The block shall be a 2-entry in-order FIFO; all outputs shall come from registers, with no combinational path from result or in_valid to any output.
REQ-015 A push shall occur when in_valid and in_ready are both 1; a pop shall occur when out_valid and out_ready are both 1.
REQ-016 in_ready shall equal (count < 2), computed from registered count only, and shall not depend on out_ready.
REQ-017 Latency: a result pushed at edge N into an empty buffer shall appear on out_data with out_valid=1 after edge N.
REQ-018 Push and pop in the same cycle with count=1 shall leave count=1, with the new entry at the head.
REQ-019 Push and pop in the same cycle with count=0 cannot occur; a push into an empty buffer shall never bypass to the output combinationally.
REQ-020 At count=2 there shall be no push, since in_ready=0; a pop shall make count=1 and in_ready=1 on the next cycle.
REQ-021 At count=0, out_valid shall be 0 and out_data, out_zero and out_neg shall hold their last values; out_ready shall be ignored.
REQ-022 out_data, out_zero and out_neg shall stay stable while out_valid=1 and out_ready=0.
REQ-023 When flush=1, count shall become 0 and out_valid 0 on the next edge; any push or pop in the same cycle shall be discarded.
REQ-024 Entry ordering shall wrap correctly through arbitrary push/pop sequences; the block shall never lose, duplicate or reorder an entry.
REQ-025 count shall never exceed 2 and shall never go below 0.

Reset
REQ-026 When reset=1 at a rising edge: count=0, out_valid=0, out_data=0, out_zero=0, out_neg=0, and in_ready=1 from the following cycle.
REQ-027 reset shall take priority over flush, push and pop; entries in flight mid-operation shall be discarded.

Configuration
REQ-028 Macro ALU_RESULT_FLAGS_EN, when defined: each entry shall store zero = (result == 0) and neg = result[size-1], both computed at push, and shall present them on out_zero and out_neg.
REQ-029 Macro ALU_RESULT_FLAGS_EN, when undefined: flag storage shall be omitted, and out_zero and out_neg shall be constant 0; the ports shall remain present.

Verification
REQ-030 Scenario: reset, then push result=4'h5 with out_ready=0 -> next cycle out_valid=1, out_data=5, count=1, in_ready=1.
REQ-031 Scenario: push 4'h3 then 4'h0 with out_ready=0 -> count=2, in_ready=0; a third in_valid with 4'h9 is not accepted; popping twice yields 3 then 0.
REQ-032 Scenario: count=1 holding 4'h1, simultaneous push 4'h2 and pop -> count stays 1 and out_data=2.
REQ-033 Scenario: with ALU_RESULT_FLAGS_EN, push 4'h0 then 4'h8 -> head flags zero=1, neg=0, then zero=0, neg=1; without the macro both flags remain 0.
REQ-034 Scenario: count=2, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0; no entry is retained.
REQ-035 Scenario: count=2, assert reset together with flush and pop -> next cycle count=0, out_data=0, in_ready=1.

Source files
------------

// File: rtl/alu_result_buffer.sv
// Two-entry in-order result buffer; every output is driven from a flop.
// Optional feature macro ALU_RESULT_FLAGS_EN stores zero/negative flags alongside each entry.
module alu_result_buffer #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [size-1:0] result,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [size-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_zero,
  output logic            out_neg,
  output logic [1:0]      count
);

  logic [size-1:0] head_q, head_d;
  logic [size-1:0] tail_q, tail_d;
  logic [1:0]      count_q, count_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic            push_s;
  logic            pop_s;
  logic            load_head_s;
  logic            load_tail_s;
  logic            shift_s;

  assign push_s = in_valid & ready_q;
  assign pop_s  = valid_q & out_ready;

  // Next-state for count and the two data slots; head_q is the visible head
  always_comb begin
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    load_head_s = 1'b0;
    load_tail_s = 1'b0;
    shift_s     = 1'b0;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          count_d = count_q + 2'd1;
          if (count_q == 2'd0) begin
            load_head_s = 1'b1;
          end else begin
            load_tail_s = 1'b1;
          end
        end
        2'b01: begin
          count_d = count_q - 2'd1;
          // Popping the last entry leaves the head register holding its value
          if (count_q == 2'd2) begin
            shift_s = 1'b1;
          end else begin
            shift_s = 1'b0;
          end
        end
        2'b11: begin
          // Only reachable at count 1: the new result replaces the departing head
          count_d     = count_q;
          load_head_s = 1'b1;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
    if (load_head_s) begin
      head_d = result;
    end else if (shift_s) begin
      head_d = tail_q;
    end else begin
      head_d = head_q;
    end
    if (load_tail_s) begin
      tail_d = result;
    end else begin
      tail_d = tail_q;
    end
    valid_d = (count_d != 2'd0);
    ready_d = (count_d != 2'd2);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= {size{1'b0}};
      tail_q  <= {size{1'b0}};
      count_q <= 2'd0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = head_q;
  assign out_valid = valid_q;
  assign count     = count_q;

`ifdef ALU_RESULT_FLAGS_EN
  function automatic logic zero_of(input logic [size-1:0] val);
    return (val == {size{1'b0}});
  endfunction

  function automatic logic neg_of(input logic [size-1:0] val);
    return val[size-1];
  endfunction

  logic head_zero_q, head_zero_d;
  logic head_neg_q,  head_neg_d;
  logic tail_zero_q, tail_zero_d;
  logic tail_neg_q,  tail_neg_d;

  // Flags follow their data entry through the same load/shift decisions
  always_comb begin
    head_zero_d = head_zero_q;
    head_neg_d  = head_neg_q;
    tail_zero_d = tail_zero_q;
    tail_neg_d  = tail_neg_q;
    if (load_head_s) begin
      head_zero_d = zero_of(result);
      head_neg_d  = neg_of(result);
    end else if (shift_s) begin
      head_zero_d = tail_zero_q;
      head_neg_d  = tail_neg_q;
    end else begin
      head_zero_d = head_zero_q;
      head_neg_d  = head_neg_q;
    end
    if (load_tail_s) begin
      tail_zero_d = zero_of(result);
      tail_neg_d  = neg_of(result);
    end else begin
      tail_zero_d = tail_zero_q;
      tail_neg_d  = tail_neg_q;
    end
  end

  // Flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      head_zero_q <= 1'b0;
      head_neg_q  <= 1'b0;
      tail_zero_q <= 1'b0;
      tail_neg_q  <= 1'b0;
    end else begin
      head_zero_q <= head_zero_d;
      head_neg_q  <= head_neg_d;
      tail_zero_q <= tail_zero_d;
      tail_neg_q  <= tail_neg_d;
    end
  end

  assign out_zero = head_zero_q;
  assign out_neg  = head_neg_q;
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_alu_result_buffer;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [3:0] result;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_zero;
  logic       out_neg;
  logic [1:0] count;

  int vectors;
  int miscompares;

`ifdef ALU_RESULT_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  alu_result_buffer #(.size(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .result(result),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_zero(out_zero),
    .out_neg(out_neg), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic iv, input logic [3:0] r, input logic ordy,
                      input logic fl, input logic rs);
    in_valid  = iv;
    result    = r;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({count, out_valid, out_data, out_zero, out_neg, in_ready} !== {2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset: got cnt=%0d v=%b d=%h z=%b n=%b rdy=%b, want cnt=0 v=0 d=0 z=0 n=0 rdy=1",
               count, out_valid, out_data, out_zero, out_neg, in_ready);
    end
  endtask

  task automatic test_push_basic();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({out_valid, out_data, count, in_ready} !== {1'b1, 4'h5, 2'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL push_basic: got v=%b d=%h cnt=%0d rdy=%b, want v=1 d=5 cnt=1 rdy=1",
               out_valid, out_data, count, in_ready);
    end
  endtask

  task automatic test_fill();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({count, in_ready, out_data} !== {2'd2, 1'b0, 4'h3}) begin
      miscompares++;
      $display("FAIL fill_full: got cnt=%0d rdy=%b d=%h, want cnt=2 rdy=0 d=3", count, in_ready, out_data);
    end
    step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({count, out_data} !== {2'd2, 4'h3}) begin
      miscompares++;
      $display("FAIL fill_reject: got cnt=%0d d=%h, want cnt=2 d=3", count, out_data);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({count, in_ready, out_valid, out_data} !== {2'd1, 1'b1, 1'b1, 4'h0}) begin
      miscompares++;
      $display("FAIL fill_pop1: got cnt=%0d rdy=%b v=%b d=%h, want cnt=1 rdy=1 v=1 d=0",
               count, in_ready, out_valid, out_data);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({count, out_valid, out_data} !== {2'd0, 1'b0, 4'h0}) begin
      miscompares++;
      $display("FAIL fill_pop2: got cnt=%0d v=%b d=%h, want cnt=0 v=0 d=0 (held)", count, out_valid, out_data);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({count, out_valid} !== {2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL fill_underflow: got cnt=%0d v=%b, want cnt=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_push_pop();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({count, out_valid, out_data} !== {2'd1, 1'b1, 4'h2}) begin
      miscompares++;
      $display("FAIL push_pop: got cnt=%0d v=%b d=%h, want cnt=1 v=1 d=2", count, out_valid, out_data);
    end
  endtask

  task automatic test_flags();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({out_zero, out_neg} !== {FLAGS, 1'b0}) begin
      miscompares++;
      $display("FAIL flags_zero: got z=%b n=%b, want z=%b n=0", out_zero, out_neg, FLAGS);
    end
    step(1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({out_data, out_zero, out_neg} !== {4'h8, 1'b0, FLAGS}) begin
      miscompares++;
      $display("FAIL flags_neg: got d=%h z=%b n=%b, want d=8 z=0 n=%b", out_data, out_zero, out_neg, FLAGS);
    end
  endtask

  task automatic test_flush();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hA, 1'b1, 1'b1, 1'b0);
    vectors++;
    if ({count, out_valid, in_ready} !== {2'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL flush: got cnt=%0d v=%b rdy=%b, want cnt=0 v=0 rdy=1", count, out_valid, in_ready);
    end
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({count, out_valid} !== {2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL flush_retain: got cnt=%0d v=%b, want cnt=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_reset_priority();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hE, 1'b1, 1'b1, 1'b1);
    vectors++;
    if ({count, out_valid, out_data, in_ready, out_zero, out_neg} !== {2'd0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_priority: got cnt=%0d v=%b d=%h rdy=%b z=%b n=%b, want cnt=0 v=0 d=0 rdy=1 z=0 n=0",
               count, out_valid, out_data, in_ready, out_zero, out_neg);
    end
  endtask

  task automatic test_random();
    logic [3:0] q[$];
    logic [3:0] last_data;
    logic       last_zero, last_neg;
    logic       iv, ordy, fl, rs;
    logic [3:0] r;
    logic [9:0] exp_v, got_v;
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    q.delete();
    last_data = 4'h0;
    last_zero = 1'b0;
    last_neg  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      rs   = ($urandom_range(0, 40) == 0);
      r    = 4'($urandom);
      if (rs) begin
        q.delete();
        last_data = 4'h0;
        last_zero = 1'b0;
        last_neg  = 1'b0;
      end else if (fl) begin
        q.delete();
      end else begin
        bit do_push, do_pop;
        do_push = iv && (q.size() < 2);
        do_pop  = ordy && (q.size() > 0);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(r);
      end
      if (q.size() > 0) begin
        last_data = q[0];
        last_zero = FLAGS && (q[0] == 4'h0);
        last_neg  = FLAGS && q[0][3];
      end
      step(iv, r, ordy, fl, rs);
      exp_v = {2'(q.size()), q.size() > 0, q.size() < 2, last_data, last_zero, last_neg};
      got_v = {count, out_valid, in_ready, out_data, out_zero, out_neg};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL random[%0d]: got {cnt,v,rdy,d,z,n}=%b, want %b", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    flush       = 1'b0;
    result      = 4'h0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_push_basic();
    test_fill();
    test_push_pop();
    test_flags();
    test_flush();
    test_reset_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
